// File: rtl/mont_exp_pkg.sv
// Shared constants and encodings for the modular exponentiation controller
// and its Montgomery multiplier.
package mont_exp_pkg;

  // Operand/modulus width, fixed by the multiplier datapath.
  localparam int N   = 1024;
  // Exponent-length field width; 2^ELW must exceed N so that t=N fits.
  localparam int ELW = 11;
  // Width of a bit index into an N-bit exponent.
  localparam int IW  = $clog2(N);

  // Multiplier consumes this many multiplier bits per clock.
  localparam int MM_BPC   = 32;
  localparam int MM_STEPS = N / MM_BPC;
  localparam int MM_CW    = $clog2(MM_STEPS);

  localparam logic [N-1:0]   ONE     = {{(N-1){1'b0}}, 1'b1};
  localparam logic [ELW-1:0] IDX_ONE = {{(ELW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FIN   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_PRE  = 2'd0,
    OP_SQ   = 2'd1,
    OP_MUL  = 2'd2,
    OP_POST = 2'd3
  } op_t;

endpackage

// File: rtl/mont_exp_if.sv
// Request/response bundle between a client and the exponentiation controller.
interface mont_exp_if;
  import mont_exp_pkg::*;

  logic           start;
  logic [N-1:0]   in_x;
  logic [N-1:0]   in_e;
  logic [ELW-1:0] in_e_len;
  logic [N-1:0]   in_m;
  logic [N-1:0]   in_r;
  logic [N-1:0]   in_r2;
  logic [N-1:0]   result;
  logic           done;
  logic           busy;

  modport master (
    output start, in_x, in_e, in_e_len, in_m, in_r, in_r2,
    input  result, done, busy
  );

  modport slave (
    input  start, in_x, in_e, in_e_len, in_m, in_r, in_r2,
    output result, done, busy
  );

endinterface

// File: rtl/mont_exp_montgomery.sv
// Radix-2 Montgomery multiplier: result = a * b * 2^-N mod m.
// Processes MM_BPC bits of a per clock (LSB first), so one product takes
// MM_STEPS clocks after start. Inputs must be < m and m must be odd.
module montgomery
  import mont_exp_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic [N-1:0] result,
  output logic         done
);

  localparam logic [MM_CW-1:0] CNT_LAST = MM_CW'(MM_STEPS - 1);

  logic [N-1:0]   aSh;
  logic [N-1:0]   bReg;
  logic [N-1:0]   mReg;
  // Accumulator stays below 2m, so two guard bits cover the add of b and m.
  logic [N+1:0]   acc;
  logic [N+1:0]   accNext;
  logic [N+1:0]   sum;
  logic [N+1:0]   mExt;
  logic [N-1:0]   reduced;
  logic [MM_CW-1:0] cnt;
  logic           running;

  assign mExt = {2'b00, mReg};

  // One clock's worth of radix-2 steps plus the final conditional subtract.
  always_comb begin
    accNext = acc;
    sum     = '0;
    for (int k = 0; k < MM_BPC; k++) begin
      sum = accNext + (aSh[k] ? {2'b00, bReg} : '0);
      if (sum[0]) begin
        sum = sum + mExt;
      end
      accNext = sum >> 1;
    end
    if (accNext >= mExt) begin
      reduced = N'(accNext - mExt);
    end else begin
      reduced = N'(accNext);
    end
  end

  // Load operands on start, iterate, and pulse done with the reduced product.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      aSh     <= '0;
      bReg    <= '0;
      mReg    <= '0;
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      result  <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !running) begin
        aSh     <= in_a;
        bReg    <= in_b;
        mReg    <= in_m;
        acc     <= '0;
        cnt     <= CNT_LAST;
        running <= 1'b1;
      end else if (running) begin
        acc <= accNext;
        aSh <= aSh >> MM_BPC;
        if (cnt == '0) begin
          running <= 1'b0;
          done    <= 1'b1;
          result  <= reduced;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mont_exp.sv
// Left-to-right binary modular exponentiation, result = X^E mod M, built on
// the Montgomery multiplier. Enters the Montgomery domain with X*R^2, runs
// the square/multiply ladder over the low t exponent bits, then exits by
// multiplying with 1.
//
//   state | meaning
//   IDLE  | waiting for start; holds last result
//   ISSUE | present operands for current op, fire multiplier start
//   WAIT  | wait for multiplier done, store product, pick next op
//   FIN   | publish result and pulse done
module mont_exp
  import mont_exp_pkg::*;
(
  input logic       clk,
  input logic       resetn,
  mont_exp_if.slave bus
);

  state_t         state;
  op_t            op;
  logic [N-1:0]   xReg;
  logic [N-1:0]   eReg;
  logic [N-1:0]   mReg;
  logic [N-1:0]   r2Reg;
  logic [N-1:0]   aReg;
  logic [N-1:0]   xtReg;
  // Exponent bit currently being processed; needs ELW bits to hold t=N.
  logic [ELW-1:0] idx;
  logic           lastBit;

  logic           mmStart;
  logic           mmDone;
  logic [N-1:0]   mmA;
  logic [N-1:0]   mmB;
  logic [N-1:0]   mmResult;

  logic [N-1:0]   resultReg;
  logic           doneReg;
  logic           busyReg;

  assign bus.result = resultReg;
  assign bus.done   = doneReg;
  assign bus.busy   = busyReg;

  assign lastBit = (idx == '0);

  // Operand select from the registered op, stable for the whole multiply.
  always_comb begin
    mmA = aReg;
    mmB = aReg;
    case (op)
      OP_PRE: begin
        mmA = xReg;
        mmB = r2Reg;
      end
      OP_SQ: begin
        mmA = aReg;
        mmB = aReg;
      end
      OP_MUL: begin
        mmA = aReg;
        mmB = xtReg;
      end
      OP_POST: begin
        mmA = aReg;
        mmB = ONE;
      end
      default: begin
        mmA = aReg;
        mmB = aReg;
      end
    endcase
  end

  // Sequencer: accepts requests, issues ops, steps the exponent ladder.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      op        <= OP_PRE;
      idx       <= '0;
      xReg      <= '0;
      eReg      <= '0;
      mReg      <= '0;
      r2Reg     <= '0;
      aReg      <= '0;
      xtReg     <= '0;
      mmStart   <= 1'b0;
      resultReg <= '0;
      doneReg   <= 1'b0;
      busyReg   <= 1'b0;
    end else begin
      mmStart <= 1'b0;
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          // busy stays up through the done cycle, drops on the next one
          busyReg <= 1'b0;
          if (bus.start) begin
            xReg    <= bus.in_x;
            eReg    <= bus.in_e;
            mReg    <= bus.in_m;
            r2Reg   <= bus.in_r2;
            aReg    <= bus.in_r;
            idx     <= bus.in_e_len;
            op      <= OP_PRE;
            busyReg <= 1'b1;
            state   <= ISSUE;
          end
        end

        ISSUE: begin
          mmStart <= 1'b1;
          state   <= WAIT;
        end

        WAIT: begin
          if (mmDone) begin
            state <= ISSUE;
            case (op)
              OP_PRE: begin
                xtReg <= mmResult;
                if (lastBit) begin
                  op <= OP_POST;
                end else begin
                  idx <= idx - IDX_ONE;
                  op  <= OP_SQ;
                end
              end
              OP_SQ: begin
                aReg <= mmResult;
                // idx was decremented before this square, so it is < N here
                if (eReg[idx[IW-1:0]]) begin
                  op <= OP_MUL;
                end else if (lastBit) begin
                  op <= OP_POST;
                end else begin
                  idx <= idx - IDX_ONE;
                  op  <= OP_SQ;
                end
              end
              OP_MUL: begin
                aReg <= mmResult;
                if (lastBit) begin
                  op <= OP_POST;
                end else begin
                  idx <= idx - IDX_ONE;
                  op  <= OP_SQ;
                end
              end
              OP_POST: begin
                aReg  <= mmResult;
                state <= FIN;
              end
              default: begin
                state <= IDLE;
              end
            endcase
          end
        end

        FIN: begin
          resultReg <= aReg;
          doneReg   <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  montgomery mmCore (
    .clk    (clk),
    .resetn (resetn),
    .start  (mmStart),
    .in_a   (mmA),
    .in_b   (mmB),
    .in_m   (mReg),
    .result (mmResult),
    .done   (mmDone)
  );

endmodule
